// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: turns EX/MEM access controls into a valid/ready
// data-bus transaction and returns the extended load result. Optional: LSU_TIMEOUT_EN.
module mem_lsu #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned MODE_W         = 3,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [MODE_W-1:0] mem_mode_i,
  input  logic [DATA_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] load_data_o,
  output logic              done_o,
  output logic              misalign_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [DATA_W-1:0] req_addr_o,
  output logic [3:0]        req_wstrb_o,
  output logic [DATA_W-1:0] req_wdata_o,
  input  logic              rsp_valid_i,
  input  logic [DATA_W-1:0] rsp_rdata_i,
  output logic              bus_err_o
);

  localparam int unsigned OFF_W = 2;
  localparam logic [MODE_W-1:0] MODE_B  = MODE_W'(0);
  localparam logic [MODE_W-1:0] MODE_H  = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_BU = MODE_W'(4);
  localparam logic [MODE_W-1:0] MODE_HU = MODE_W'(5);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t              state_q, state_d;
  logic [MODE_W-1:0]   lat_mode_q, lat_mode_d;
  logic [OFF_W-1:0]    lat_off_q, lat_off_d;
  logic [DATA_W-1:0]   load_data_d;
  logic                done_d, misalign_d;
  logic                req_valid_d, req_we_d;
  logic [DATA_W-1:0]   req_addr_d, req_wdata_d;
  logic [3:0]          req_wstrb_d;
  logic                access;

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign bus_err_o = 1'b0;
`endif

  function automatic logic is_misaligned(input logic [MODE_W-1:0] mode,
                                         input logic [OFF_W-1:0]  off);
    case (mode)
      MODE_B, MODE_BU: return 1'b0;
      MODE_H, MODE_HU: return off[0];
      default:         return off != '0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [MODE_W-1:0] mode,
                                            input logic [OFF_W-1:0]  off);
    case (mode)
      MODE_B, MODE_BU: return 4'(4'b0001 << off);
      MODE_H, MODE_HU: return 4'(4'b0011 << off);
      default:         return 4'hF;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_data(input logic [MODE_W-1:0] mode,
                                                   input logic [DATA_W-1:0] wdata);
    case (mode)
      MODE_B, MODE_BU: return {(DATA_W/8){wdata[7:0]}};
      MODE_H, MODE_HU: return {(DATA_W/16){wdata[15:0]}};
      default:         return wdata;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then sign/zero-extend by mode.
  function automatic logic [DATA_W-1:0] extend_load(input logic [MODE_W-1:0] mode,
                                                    input logic [OFF_W-1:0]  off,
                                                    input logic [DATA_W-1:0] word);
    logic [DATA_W-1:0] lane;
    lane = word >> {off, 3'b000};
    case (mode)
      MODE_B:  return {{(DATA_W-8){lane[7]}}, lane[7:0]};
      MODE_BU: return {{(DATA_W-8){1'b0}}, lane[7:0]};
      MODE_H:  return {{(DATA_W-16){lane[15]}}, lane[15:0]};
      MODE_HU: return {{(DATA_W-16){1'b0}}, lane[15:0]};
      default: return word;
    endcase
  endfunction

  assign access  = mem_read_i | mem_write_i;
  assign stall_o = ((state_q == IDLE) & access) | (state_q == REQ) | (state_q == WAIT);

  // Next-state and next registered-output logic.
  always_comb begin
    state_d     = state_q;
    lat_mode_d  = lat_mode_q;
    lat_off_d   = lat_off_q;
    load_data_d = load_data_o;
    done_d      = 1'b0;
    misalign_d  = 1'b0;
    req_valid_d = req_valid_o;
    req_we_d    = req_we_o;
    req_addr_d  = req_addr_o;
    req_wstrb_d = req_wstrb_o;
    req_wdata_d = req_wdata_o;
`ifdef LSU_TIMEOUT_EN
    cnt_d       = cnt_q;
    bus_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (access) begin
          lat_mode_d = mem_mode_i;
          lat_off_d  = addr_i[OFF_W-1:0];
          if (is_misaligned(mem_mode_i, addr_i[OFF_W-1:0])) begin
            state_d     = DONE;
            done_d      = 1'b1;
            misalign_d  = 1'b1;
            load_data_d = '0;
          end else begin
            state_d     = REQ;
            req_valid_d = 1'b1;
            req_we_d    = mem_write_i;
            req_addr_d  = {addr_i[DATA_W-1:OFF_W], OFF_W'(0)};
            if (mem_write_i) begin
              req_wstrb_d = store_strb(mem_mode_i, addr_i[OFF_W-1:0]);
              req_wdata_d = store_data(mem_mode_i, wdata_i);
            end else begin
              req_wstrb_d = 4'h0;
              req_wdata_d = '0;
            end
`ifdef LSU_TIMEOUT_EN
            cnt_d = '0;
`endif
          end
        end
      end
      REQ: begin
        if (req_ready_i) begin
          req_valid_d = 1'b0;
          if (req_we_o) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (rsp_valid_i) begin
          load_data_d = extend_load(lat_mode_q, lat_off_q, rsp_rdata_i);
          state_d     = DONE;
          done_d      = 1'b1;
        end
      end
      DONE: state_d = IDLE;
    endcase

`ifdef LSU_TIMEOUT_EN
    // Watchdog: a completion in the same cycle takes priority over the timeout.
    if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (state_d != DONE && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        state_d     = DONE;
        done_d      = 1'b1;
        bus_err_d   = 1'b1;
        load_data_d = '0;
        req_valid_d = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_mode_q  <= '0;
      lat_off_q   <= '0;
      load_data_o <= '0;
      done_o      <= 1'b0;
      misalign_o  <= 1'b0;
      req_valid_o <= 1'b0;
      req_we_o    <= 1'b0;
      req_addr_o  <= '0;
      req_wstrb_o <= 4'h0;
      req_wdata_o <= '0;
    end else begin
      state_q     <= state_d;
      lat_mode_q  <= lat_mode_d;
      lat_off_q   <= lat_off_d;
      load_data_o <= load_data_d;
      done_o      <= done_d;
      misalign_o  <= misalign_d;
      req_valid_o <= req_valid_d;
      req_we_o    <= req_we_d;
      req_addr_o  <= req_addr_d;
      req_wstrb_o <= req_wstrb_d;
      req_wdata_o <= req_wdata_d;
    end
  end

`ifdef LSU_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      bus_err_o <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_o <= bus_err_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: a small bus responder plus expected-result queue.
module tb_mem_lsu;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned MODE_W         = 3;
  localparam int unsigned TIMEOUT_CYCLES = 16;
  localparam int          BUDGET         = 60;

  logic              clk = 1'b0;
  logic              rst;
  logic              mem_read_i, mem_write_i;
  logic [MODE_W-1:0] mem_mode_i;
  logic [DATA_W-1:0] addr_i, wdata_i;
  logic              stall_o;
  logic [DATA_W-1:0] load_data_o;
  logic              done_o, misalign_o;
  logic              req_valid_o, req_ready_i, req_we_o;
  logic [DATA_W-1:0] req_addr_o, req_wdata_o;
  logic [3:0]        req_wstrb_o;
  logic              rsp_valid_i;
  logic [DATA_W-1:0] rsp_rdata_i;
  logic              bus_err_o;

  always #5 clk = ~clk;

  mem_lsu #(.DATA_W(DATA_W), .MODE_W(MODE_W), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i), .mem_mode_i(mem_mode_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .done_o(done_o), .misalign_o(misalign_o),
    .req_valid_o(req_valid_o), .req_ready_i(req_ready_i), .req_we_o(req_we_o),
    .req_addr_o(req_addr_o), .req_wstrb_o(req_wstrb_o), .req_wdata_o(req_wdata_o),
    .rsp_valid_i(rsp_valid_i), .rsp_rdata_i(rsp_rdata_i), .bus_err_o(bus_err_o)
  );

  typedef struct {
    logic [31:0] data;
    logic        misalign;
    logic        bus_err;
    int          stalls;
    int          valids;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk_exp(input logic [31:0] data, input logic mis, input logic berr,
                                  input int stalls, input int valids);
    exp_t e;
    e.data = data; e.misalign = mis; e.bus_err = berr; e.stalls = stalls; e.valids = valids;
    return e;
  endfunction

  // Drives one access, plays the memory side, and checks the result at done_o.
  task automatic run_access(input string name, input logic rd, input logic wr,
                            input logic [2:0] mode, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ready_delay,
                            input logic give_rsp, input logic [31:0] rsp_word,
                            input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input exp_t exp);
    int   stalls, nvalid;
    logic acc_prev, acc_now, seen_done;
    exp_t e;
    sb_q.push_back(exp);
    @(negedge clk);
    mem_read_i = rd; mem_write_i = wr; mem_mode_i = mode; addr_i = addr; wdata_i = wdata;
    #1;
    stalls    = (stall_o === 1'b1) ? 1 : 0;
    nvalid    = 0;
    acc_prev  = 1'b0;
    seen_done = 1'b0;
    for (int cyc = 0; cyc < BUDGET && !seen_done; cyc++) begin
      @(negedge clk);
      if (done_o === 1'b1) begin
        seen_done = 1'b1;
        e = sb_q.pop_front();
        check_eq({name, " load_data"}, load_data_o, e.data);
        check_eq({name, " misalign"}, 32'(misalign_o), 32'(e.misalign));
        check_eq({name, " bus_err"}, 32'(bus_err_o), 32'(e.bus_err));
        check_eq({name, " stall_in_done"}, 32'(stall_o), 32'd0);
        check_eq({name, " stall_cycles"}, 32'(stalls), 32'(e.stalls));
        check_eq({name, " valid_cycles"}, 32'(nvalid), 32'(e.valids));
        mem_read_i = 1'b0; mem_write_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
      end else begin
        if (stall_o === 1'b1) stalls++;
        acc_now = 1'b0;
        if (req_valid_o === 1'b1) begin
          check_eq({name, " req_addr"}, req_addr_o, exp_addr);
          check_eq({name, " req_we"}, 32'(req_we_o), 32'(wr));
          check_eq({name, " req_wstrb"}, 32'(req_wstrb_o), 32'(exp_strb));
          if (wr) check_eq({name, " req_wdata"}, req_wdata_o, exp_wdata);
          acc_now = (nvalid == ready_delay);
          nvalid++;
        end
        req_ready_i = acc_now;
        // Junk responses while the request is pending must be ignored.
        if (acc_prev && rd && !wr) begin
          rsp_valid_i = give_rsp;
          rsp_rdata_i = rsp_word;
        end else begin
          rsp_valid_i = (req_valid_o === 1'b1);
          rsp_rdata_i = 32'h5A5A_5A5A;
        end
        acc_prev = acc_now;
      end
    end
    if (!seen_done) begin
      check_eq({name, " done_seen"}, 32'(seen_done), 32'd1);
      e = sb_q.pop_front();
      mem_read_i = 1'b0; mem_write_i = 1'b0; req_ready_i = 1'b0; rsp_valid_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    @(negedge clk);
    check_eq({name, " done_pulse"}, 32'(done_o), 32'd0);
    check_eq({name, " misalign_pulse"}, 32'(misalign_o), 32'd0);
    check_eq({name, " idle_stall"}, 32'(stall_o), 32'd0);
    check_eq({name, " idle_valid"}, 32'(req_valid_o), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_read_i = 1'b0; mem_write_i = 1'b0; mem_mode_i = '0;
    addr_i = '0; wdata_i = '0; req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_rdata_i = '0;
    repeat (2) @(negedge clk);
    check_eq("rst load_data", load_data_o, 32'd0);
    check_eq("rst done", 32'(done_o), 32'd0);
    check_eq("rst misalign", 32'(misalign_o), 32'd0);
    check_eq("rst req_valid", 32'(req_valid_o), 32'd0);
    check_eq("rst req_we", 32'(req_we_o), 32'd0);
    check_eq("rst req_addr", req_addr_o, 32'd0);
    check_eq("rst req_wstrb", 32'(req_wstrb_o), 32'd0);
    check_eq("rst req_wdata", req_wdata_o, 32'd0);
    check_eq("rst bus_err", 32'(bus_err_o), 32'd0);
    check_eq("rst stall", 32'(stall_o), 32'd0);
    rst = 1'b0;

    //           name      rd wr mode    addr          wdata         dly rsp word          exp addr     strb   wdata
    run_access("lw",      1, 0, 3'b010, 32'h100, 32'h0,          0, 1, 32'hDEADBEEF, 32'h100, 4'h0, 32'h0,
               mk_exp(32'hDEADBEEF, 0, 0, 3, 1));
    run_access("lb",      1, 0, 3'b000, 32'h103, 32'h0,          0, 1, 32'h80112233, 32'h100, 4'h0, 32'h0,
               mk_exp(32'hFFFFFF80, 0, 0, 3, 1));
    run_access("lbu",     1, 0, 3'b100, 32'h103, 32'h0,          0, 1, 32'h80112233, 32'h100, 4'h0, 32'h0,
               mk_exp(32'h00000080, 0, 0, 3, 1));
    run_access("sh",      0, 1, 3'b001, 32'h22,  32'h0000ABCD,   4, 0, 32'h0,        32'h20,  4'hC, 32'hABCDABCD,
               mk_exp(32'h00000080, 0, 0, 6, 5));
    run_access("lw_mis",  1, 0, 3'b010, 32'h102, 32'h0,          0, 1, 32'h0,        32'h0,   4'h0, 32'h0,
               mk_exp(32'h0, 1, 0, 1, 0));
    run_access("lh",      1, 0, 3'b001, 32'h102, 32'h0,          2, 1, 32'h80112233, 32'h100, 4'h0, 32'h0,
               mk_exp(32'hFFFF8011, 0, 0, 5, 3));
    run_access("lhu",     1, 0, 3'b101, 32'h100, 32'h0,          0, 1, 32'h80112233, 32'h100, 4'h0, 32'h0,
               mk_exp(32'h00002233, 0, 0, 3, 1));
    run_access("sb",      0, 1, 3'b000, 32'h101, 32'h123456A5,   1, 0, 32'h0,        32'h100, 4'h2, 32'hA5A5A5A5,
               mk_exp(32'h00002233, 0, 0, 3, 2));
    run_access("sw",      0, 1, 3'b010, 32'h104, 32'hCAFEF00D,   0, 0, 32'h0,        32'h104, 4'hF, 32'hCAFEF00D,
               mk_exp(32'h00002233, 0, 0, 2, 1));
    run_access("rw_both", 1, 1, 3'b010, 32'h10C, 32'h11223344,   0, 0, 32'h0,        32'h10C, 4'hF, 32'h11223344,
               mk_exp(32'h00002233, 0, 0, 2, 1));
    run_access("mode011", 1, 0, 3'b011, 32'h108, 32'h0,          0, 1, 32'h01020304, 32'h108, 4'h0, 32'h0,
               mk_exp(32'h01020304, 0, 0, 3, 1));
    run_access("m111_mis",1, 0, 3'b111, 32'h10A, 32'h0,          0, 1, 32'h0,        32'h0,   4'h0, 32'h0,
               mk_exp(32'h0, 1, 0, 1, 0));
    run_access("lhu_mis", 1, 0, 3'b101, 32'h101, 32'h0,          0, 1, 32'h0,        32'h0,   4'h0, 32'h0,
               mk_exp(32'h0, 1, 0, 1, 0));
    run_access("lb_pos",  1, 0, 3'b000, 32'h101, 32'h0,          0, 1, 32'h00007F00, 32'h100, 4'h0, 32'h0,
               mk_exp(32'h0000007F, 0, 0, 3, 1));
`ifdef LSU_TIMEOUT_EN
    run_access("timeout", 1, 0, 3'b010, 32'h200, 32'h0,          0, 0, 32'h0,        32'h200, 4'h0, 32'h0,
               mk_exp(32'h0, 0, 1, 17, 1));
`endif

    // Reset while a load sits in WAIT; a late response must be ignored.
    @(negedge clk);
    mem_read_i = 1'b1; mem_write_i = 1'b0; mem_mode_i = 3'b010; addr_i = 32'h300;
    @(negedge clk);
    check_eq("rstw req_valid", 32'(req_valid_o), 32'd1);
    req_ready_i = 1'b1;
    @(negedge clk);
    req_ready_i = 1'b0;
    check_eq("rstw wait_stall", 32'(stall_o), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; mem_read_i = 1'b0;
    #1;
    check_eq("rstw req_valid_after", 32'(req_valid_o), 32'd0);
    check_eq("rstw stall_after", 32'(stall_o), 32'd0);
    check_eq("rstw load_data_after", load_data_o, 32'd0);
    rsp_valid_i = 1'b1; rsp_rdata_i = 32'h12345678;
    @(negedge clk);
    rsp_valid_i = 1'b0;
    check_eq("rstw late_rsp_done", 32'(done_o), 32'd0);
    check_eq("rstw late_rsp_data", load_data_o, 32'd0);
    check_eq("rstw late_rsp_stall", 32'(stall_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
